// File: rtl/multicycle_control_pkg.sv
// Shared types for the multicycle controller: states, opcodes,
// datapath select encodings and the per-state control bundle.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_TRAP     = 4'd9
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALUOP_ADD    = 3'b000;
  localparam logic [2:0] ALUOP_SUB    = 3'b001;
  localparam logic [2:0] ALUOP_RFUNCT = 3'b010;
  localparam logic [2:0] ALUOP_IFUNCT = 3'b011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       oldpc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       memto_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       pc_source;
  } ctrl_t;

  // States that own the memory port and may stall on MemReady
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle.
interface multicycle_control_if;

  logic [6:0] Opcode;
  logic       Zero;
  logic       MemReady;

  logic        PCWrite;
  logic        OldPCWrite;
  logic        IRWrite;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite;
  logic        MemtoReg;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUOp;
  logic        PCSource;
  logic        Illegal;
  logic        BusError;
  logic [31:0] InstRet;

  modport master (
    input  Opcode, Zero, MemReady,
    output PCWrite, OldPCWrite, IRWrite, IorD,
    output MemRead, MemWrite, RegWrite, MemtoReg,
    output ALUSrcA, ALUSrcB, ALUOp, PCSource,
    output Illegal, BusError, InstRet
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  PCWrite, OldPCWrite, IRWrite, IorD,
    input  MemRead, MemWrite, RegWrite, MemtoReg,
    input  ALUSrcA, ALUSrcB, ALUOp, PCSource,
    input  Illegal, BusError, InstRet
  );

endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts stalled cycles of the current memory access and flags
// the cycle on which the access has waited MAX_WAIT cycles.
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wait_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int unsigned CW =
    (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CW-1:0] LAST =
    (MAX_WAIT == 0) ? '0 : CW'(MAX_WAIT - 1);
  localparam logic EN = (MAX_WAIT != 0);

  logic [CW-1:0] cnt_q, cnt_d;

  // A completed access or leaving a memory state restarts the count
  always_comb begin
    cnt_d = '0;
    if (wait_i && !ready_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = EN && wait_i && !ready_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V sequencer: shared memory port, wait/timeout
// handling, illegal-opcode trap and retired-instruction counter.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_e      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic        buserr_q, buserr_d;
  logic [31:0] instret_q, instret_d;
  logic        timeout;
  ctrl_t       ctl, ctl_g;

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk_i     (clk),
    .rst_ni    (reset),
    .wait_i    (is_wait_state(state_q)),
    .ready_i   (bus.MemReady),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      buserr_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      buserr_q  <= buserr_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    buserr_d  = buserr_q;
    instret_d = instret_q;
    unique case (state_q)
      S_FETCH: begin
        if (bus.MemReady) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d  = S_TRAP;
          buserr_d = 1'b1;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          (bus.Opcode == OP_LOAD),
          (bus.Opcode == OP_STORE):  state_d = S_MEMADDR;
          (bus.Opcode == OP_RTYPE),
          (bus.Opcode == OP_ITYPE):  state_d = S_EXECUTE;
          (bus.Opcode == OP_BRANCH): state_d = S_BRANCH;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADDR: begin
        state_d = (bus.Opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        if (bus.MemReady) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          state_d  = S_TRAP;
          buserr_d = 1'b1;
        end
      end
      S_MEMWB: begin
        state_d   = S_FETCH;
        instret_d = instret_q + 32'd1;
      end
      S_MEMWRITE: begin
        if (bus.MemReady) begin
          state_d   = S_FETCH;
          instret_d = instret_q + 32'd1;
        end else if (timeout) begin
          state_d  = S_TRAP;
          buserr_d = 1'b1;
        end
      end
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB, S_BRANCH: begin
        state_d   = S_FETCH;
        instret_d = instret_q + 32'd1;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_comb begin
    ctl = '0;
    unique case (state_q)
      S_FETCH: begin
        ctl.mem_read    = 1'b1;
        ctl.alu_src_a   = SRCA_PC;
        ctl.alu_src_b   = SRCB_FOUR;
        ctl.alu_op      = ALUOP_ADD;
        ctl.ir_write    = bus.MemReady;
        ctl.pc_write    = bus.MemReady;
        ctl.oldpc_write = bus.MemReady;
      end
      S_DECODE: begin
        ctl.alu_src_a = SRCA_OLDPC;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_MEMADDR: begin
        ctl.alu_src_a = SRCA_A;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctl.reg_write = 1'b1;
        ctl.memto_reg = 1'b1;
      end
      S_MEMWRITE: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
      end
      S_EXECUTE: begin
        ctl.alu_src_a = SRCA_A;
        if (bus.Opcode == OP_RTYPE) begin
          ctl.alu_src_b = SRCB_B;
          ctl.alu_op    = ALUOP_RFUNCT;
        end else begin
          ctl.alu_src_b = SRCB_IMM;
          ctl.alu_op    = ALUOP_IFUNCT;
        end
      end
      S_ALUWB: begin
        ctl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a = SRCA_A;
        ctl.alu_src_b = SRCB_B;
        ctl.alu_op    = ALUOP_SUB;
        ctl.pc_source = 1'b1;
        ctl.pc_write  = bus.Zero;
      end
      default: ctl = '0;
    endcase
  end

  // Reset masks the FETCH strobes too, not just the registered state
  assign ctl_g = reset ? ctl : '0;

  assign bus.PCWrite    = ctl_g.pc_write;
  assign bus.OldPCWrite = ctl_g.oldpc_write;
  assign bus.IRWrite    = ctl_g.ir_write;
  assign bus.IorD       = ctl_g.iord;
  assign bus.MemRead    = ctl_g.mem_read;
  assign bus.MemWrite   = ctl_g.mem_write;
  assign bus.RegWrite   = ctl_g.reg_write;
  assign bus.MemtoReg   = ctl_g.memto_reg;
  assign bus.ALUSrcA    = ctl_g.alu_src_a;
  assign bus.ALUSrcB    = ctl_g.alu_src_b;
  assign bus.ALUOp      = ctl_g.alu_op;
  assign bus.PCSource   = ctl_g.pc_source;
  assign bus.Illegal    = illegal_q;
  assign bus.BusError   = buserr_q;
  assign bus.InstRet    = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control; control outputs are
// packed into one word and compared to hand-computed per-state codes.
module tb_multicycle_control;

  // {PCW,OPCW,IRW,IorD,MR,MW,RW,MtR,SrcA[2],SrcB[2],ALUOp[3],PCSrc}
  localparam logic [15:0] C_FETCH  = 16'hE810;
  localparam logic [15:0] C_FWAIT  = 16'h0810;
  localparam logic [15:0] C_DECODE = 16'h0060;
  localparam logic [15:0] C_MADDR  = 16'h00A0;
  localparam logic [15:0] C_MREAD  = 16'h1800;
  localparam logic [15:0] C_MWB    = 16'h0300;
  localparam logic [15:0] C_MWRITE = 16'h1400;
  localparam logic [15:0] C_EXEC_R = 16'h0084;
  localparam logic [15:0] C_EXEC_I = 16'h00A6;
  localparam logic [15:0] C_ALUWB  = 16'h0200;
  localparam logic [15:0] C_BR_T   = 16'h8083;
  localparam logic [15:0] C_BR_N   = 16'h0083;
  localparam logic [15:0] C_IDLE   = 16'h0000;

  logic clk;
  logic reset;
  int   nvec;
  int   nerr;

  multicycle_control_if mc_if ();

  multicycle_control #(
    .MAX_WAIT (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mc_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] outs;
  assign outs = {mc_if.PCWrite, mc_if.OldPCWrite, mc_if.IRWrite,
                 mc_if.IorD, mc_if.MemRead, mc_if.MemWrite,
                 mc_if.RegWrite, mc_if.MemtoReg, mc_if.ALUSrcA,
                 mc_if.ALUSrcB, mc_if.ALUOp, mc_if.PCSource};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Entered 1 time unit after a rising edge; checks mid-cycle
  task automatic tick(input string tag, input logic [15:0] exp);
    #2;
    chk(tag, {16'h0, outs}, {16'h0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    reset = 1'b0;
    mc_if.Opcode = 7'h33;
    mc_if.Zero = 1'b0;
    mc_if.MemReady = 1'b1;

    repeat (2) @(posedge clk);
    #3;
    chk("rst_outs", {16'h0, outs}, 32'h0);
    chk("rst_instret", mc_if.InstRet, 32'h0);
    chk("rst_flags", {30'h0, mc_if.Illegal, mc_if.BusError}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // R-type add 0x00208033
    tick("r_fetch", C_FETCH);
    tick("r_decode", C_DECODE);
    tick("r_exec", C_EXEC_R);
    #1 chk("r_instret_pre", mc_if.InstRet, 32'd0);
    #0 tick("r_aluwb", C_ALUWB);
    chk("r_instret", mc_if.InstRet, 32'd1);

    // I-type
    mc_if.Opcode = 7'h13;
    tick("i_fetch", C_FETCH);
    tick("i_decode", C_DECODE);
    tick("i_exec", C_EXEC_I);
    tick("i_aluwb", C_ALUWB);
    chk("i_instret", mc_if.InstRet, 32'd2);

    // Load 0x0000A103, three wait cycles in MEMREAD
    mc_if.Opcode = 7'h03;
    tick("ld_fetch", C_FETCH);
    tick("ld_decode", C_DECODE);
    tick("ld_maddr", C_MADDR);
    mc_if.MemReady = 1'b0;
    for (int i = 0; i < 3; i++) tick("ld_wait", C_MREAD);
    mc_if.MemReady = 1'b1;
    tick("ld_mread", C_MREAD);
    tick("ld_mwb", C_MWB);
    chk("ld_instret", mc_if.InstRet, 32'd3);

    // Store
    mc_if.Opcode = 7'h23;
    tick("st_fetch", C_FETCH);
    tick("st_decode", C_DECODE);
    tick("st_maddr", C_MADDR);
    tick("st_mwrite", C_MWRITE);
    chk("st_instret", mc_if.InstRet, 32'd4);

    // Branch 0x00000463 taken then not taken
    mc_if.Opcode = 7'h63;
    mc_if.Zero = 1'b1;
    tick("bt_fetch", C_FETCH);
    tick("bt_decode", C_DECODE);
    tick("bt_branch", C_BR_T);
    mc_if.Zero = 1'b0;
    tick("bn_fetch", C_FETCH);
    tick("bn_decode", C_DECODE);
    tick("bn_branch", C_BR_N);
    chk("br_instret", mc_if.InstRet, 32'd6);

    // 14 wait cycles then ready on the cycle the timeout would fire
    mc_if.MemReady = 1'b0;
    for (int i = 0; i < 14; i++) tick("fw_wait", C_FWAIT);
    mc_if.MemReady = 1'b1;
    tick("fw_last", C_FETCH);
    chk("fw_no_buserr", {31'h0, mc_if.BusError}, 32'h0);
    tick("fw_decode", C_DECODE);
    tick("fw_branch", C_BR_N);
    chk("fw_instret", mc_if.InstRet, 32'd7);

    // Reset mid-wait in MEMWRITE
    mc_if.Opcode = 7'h23;
    tick("rw_fetch", C_FETCH);
    tick("rw_decode", C_DECODE);
    tick("rw_maddr", C_MADDR);
    mc_if.MemReady = 1'b0;
    tick("rw_wait", C_MWRITE);
    #2;
    chk("rw_memwrite", {31'h0, mc_if.MemWrite}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rw_async_outs", {16'h0, outs}, 32'h0);
    chk("rw_instret_clr", mc_if.InstRet, 32'd0);
    @(posedge clk);
    #1;
    chk("rw_held_outs", {16'h0, outs}, 32'h0);
    reset = 1'b1;
    mc_if.MemReady = 1'b1;
    tick("rw_fetch2", C_FETCH);
    chk("rw_instret0", mc_if.InstRet, 32'd0);
    tick("rw_decode2", C_DECODE);
    tick("rw_maddr2", C_MADDR);
    tick("rw_mwrite2", C_MWRITE);
    chk("rw_instret1", mc_if.InstRet, 32'd1);

    // Bus timeout in FETCH
    mc_if.MemReady = 1'b0;
    for (int i = 0; i < 15; i++) tick("to_wait", C_FWAIT);
    chk("to_buserr", {31'h0, mc_if.BusError}, 32'h1);
    chk("to_illegal", {31'h0, mc_if.Illegal}, 32'h0);
    mc_if.MemReady = 1'b1;
    for (int i = 0; i < 3; i++) tick("to_trap", C_IDLE);
    chk("to_sticky", {31'h0, mc_if.BusError}, 32'h1);
    reset = 1'b0;
    #1;
    chk("to_rst_clr", {31'h0, mc_if.BusError}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Illegal opcode
    mc_if.Opcode = 7'h7F;
    tick("il_fetch", C_FETCH);
    tick("il_decode", C_DECODE);
    chk("il_set", {31'h0, mc_if.Illegal}, 32'h1);
    for (int i = 0; i < 20; i++) begin
      mc_if.Zero = i[0];
      mc_if.MemReady = i[1];
      tick("il_trap", C_IDLE);
    end
    chk("il_sticky", {31'h0, mc_if.Illegal}, 32'h1);
    chk("il_no_buserr", {31'h0, mc_if.BusError}, 32'h0);
    chk("il_instret", mc_if.InstRet, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Finite-state controller that sequences the team's RISC-V datapath in multicycle form, replacing the single-cycle `Control` decode. It shares one unified memory port between instruction fetch and load/store. Per state, it issues the write enables, mux selects and `ALUOp` that the existing ALU/ALUControl/Registers/PC blocks consume. It also handles memory wait states, traps illegal opcodes and bus timeouts, and counts retired instructions.

## Interface
- `MAX_WAIT`, 15: cycles a memory access may wait for `MemReady` before bus error; 0 disables the timeout.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `Opcode`  in  7  `IR[6:0]` of the latched instruction.
- `Zero`  in  1  ALU zero flag.
- `MemReady`  in  1  memory completes the current access on this edge.
- `PCWrite`  out  1  load PC.
- `OldPCWrite`  out  1  latch the current PC into OldPC.
- `IRWrite`  out  1  load instruction register.
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `MemRead` / `MemWrite`  out  1 each  memory strobes.
- `RegWrite`  out  1  register file write.
- `MemtoReg`  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = A (rs1).
- `ALUSrcB`  out  2  00 = B (rs2), 01 = constant 4, 10 = immediate.
- `ALUOp`  out  3  000 = add, 001 = branch-compare (sub), 010 = R-type funct, 011 = I-type funct.
- `PCSource`  out  1  0 = ALU result, 1 = ALUOut.
- `Illegal`  out  1  sticky; set on an unknown opcode.
- `BusError`  out  1  sticky; set on a memory timeout.
- `InstRet`  out  32  retired-instruction count.

## Operation
- States: FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, TRAP.
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=00, `ALUSrcB`=01, `ALUOp`=000. When `MemReady`=1, `IRWrite`=`PCWrite`=`OldPCWrite`=1 for that cycle only, then go to DECODE.
- DECODE: `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=000, which places the branch target in ALUOut. Dispatch on `Opcode`:
  - 0000011 or 0100011 → MEMADDR.
  - 0110011 or 0010011 → EXECUTE.
  - 1100011 → BRANCH.
  - any other opcode → TRAP, with `Illegal` set.
- MEMADDR: `ALUSrcA`=10, `ALUSrcB`=10, `ALUOp`=000. Load → MEMREAD; store → MEMWRITE.
- MEMREAD: `MemRead`=1, `IorD`=1. Hold until `MemReady`, then go to MEMWB.
- MEMWB: `RegWrite`=1, `MemtoReg`=1, then go to FETCH.
- MEMWRITE: `MemWrite`=1, `IorD`=1. Hold until `MemReady`, then go to FETCH.
- EXECUTE: `ALUSrcA`=10. `ALUSrcB`=00 with `ALUOp`=010 for R-type; `ALUSrcB`=10 with `ALUOp`=011 for I-type. Then go to ALUWB.
- ALUWB: `RegWrite`=1, `MemtoReg`=0, then go to FETCH.
- BRANCH: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=001, `PCSource`=1, `PCWrite`=`Zero`. Then go to FETCH.
- TRAP: every enable and strobe is 0. TRAP is terminal; only reset exits it.
- Wait timeout: a counter clears on entry to FETCH, MEMREAD or MEMWRITE and increments on each cycle with `MemReady`=0. When it reaches `MAX_WAIT` and `MAX_WAIT`≠0, go to TRAP with `BusError` set.
- `InstRet` increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH. It wraps modulo 2^32.
- Any output not listed for a state is 0.

## Timing
- Reset (`reset`=0): state = FETCH; counter, `InstRet`, `Illegal` and `BusError` = 0. All outputs are forced to 0 while `reset`=0, including FETCH's `MemRead`.
- Reset asserted mid-access or mid-wait: state returns to FETCH immediately. No write enable may be asserted afterwards.
- All outputs are Moore-decoded from state and `Opcode`, except that the `MemReady`-qualified enables and `PCWrite` in BRANCH are combinational on `MemReady` and `Zero`.
- With `MemReady` tied to 1, instruction latency is:
  - R-type and I-type ALU: 4 cycles.
  - load: 5 cycles.
  - store: 4 cycles.
  - branch: 3 cycles.
- Each wait cycle adds exactly 1 cycle to the instruction.
- `MemReady`=1 on the same edge the timeout would fire: the access completes and no error is raised.
- Strobes stay stable throughout a wait. `IorD` never changes while `MemRead` or `MemWrite` is high.

## Structure
- Package `multicycle_pkg` holds:
  - the state enum;
  - opcode constants (LOAD, STORE, RTYPE, ITYPE, BRANCH);
  - the `ALUOp`, `ALUSrcA` and `ALUSrcB` encodings.
- Sub-module `mem_wait_timer` holds the wait counter and timeout compare, parameterised by `MAX_WAIT`.
- Next-state and output decode stay in the top module.

## Test plan
- `MemReady`=1, R-type add 0x00208033 → states FETCH, DECODE, EXECUTE, ALUWB; `RegWrite` pulses in cycle 4; `InstRet` 0→1.
- Load 0x0000A103 with `MemReady` low for 3 cycles in MEMREAD → `MemRead`/`IorD`=1 held stable; `RegWrite`/`MemtoReg` pulse on cycle 8.
- Branch 0x00000463 with `Zero`=1 → `PCWrite`=1, `PCSource`=1 in BRANCH; with `Zero`=0 → `PCWrite`=0. Both cases take 3 cycles.
- `Opcode`=0x7F → TRAP after DECODE, `Illegal`=1 and sticky; all enables 0 for 20 cycles.
- `MemReady` held 0 in FETCH with `MAX_WAIT`=15 → `BusError` set after 15 cycles. A second run with `MemReady`=1 on cycle 15 → no error.
- `reset` pulled low in MEMWRITE mid-wait → `MemWrite` drops asynchronously; after release, FETCH with `InstRet`=0.
